// File: rtl/vslc_timer_sched_pkg.sv
// Shared constants and types for the VSLC timer scheduler: register map and
// scheduler FSM states.
package vslc_timer_sched_pkg;

  localparam logic [3:0] ADDR_PRESCALE    = 4'h0;
  localparam logic [3:0] ADDR_CTRL        = 4'h1;
  localparam logic [3:0] ADDR_ENABLE_SH   = 4'h2;
  localparam logic [3:0] ADDR_COMMIT      = 4'h3;
  localparam logic [3:0] ADDR_PERIOD_BASE = 4'h8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/tt_um_jimktrains_vslc_prescaler.sv
// Shared prescaler: toggles timer_clk every prescale+1 cycles while running and
// flags the cycle whose closing edge drives timer_clk from 1 to 0.
module tt_um_jimktrains_vslc_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] prescale,
  input  logic        clear,
  output logic        timer_clk,
  output logic        fall_strobe
);

  logic [15:0] count;
  logic        wrap;

  assign wrap        = run && !clear && (count == prescale);
  // High in the cycle before the falling edge so loads land on that edge.
  assign fall_strobe = wrap && timer_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 16'd0;
      timer_clk <= 1'b0;
    end else if (clear || !run) begin
      count     <= 16'd0;
      timer_clk <= 1'b0;
    end else if (wrap) begin
      count     <= 16'd0;
      timer_clk <= ~timer_clk;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/tt_um_jimktrains_vslc_timer_sched.sv
// Config controller and tick scheduler: shadow period/enable registers that are
// committed to the active timer outputs atomically on a timer_clk falling edge.
module tt_um_jimktrains_vslc_timer_sched
  import vslc_timer_sched_pkg::*;
#(
  parameter int NUM_TIMERS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [3:0]              cfg_addr,
  input  logic [15:0]             cfg_data,
  output logic                    cfg_err,
  output logic                    commit_pending,
  output logic                    timer_clk,
  output logic [16*NUM_TIMERS-1:0] timer_period_a,
  output logic [16*NUM_TIMERS-1:0] timer_period_b,
  output logic [NUM_TIMERS-1:0]   timer_enabled
);

  sched_state_t          state, next_state;
  logic [15:0]           prescale;
  logic                  run;
  logic [NUM_TIMERS-1:0] enable_sh;
  logic [NUM_TIMERS-1:0] commit_mask;
  logic [15:0]           a_sh [NUM_TIMERS];
  logic [15:0]           b_sh [NUM_TIMERS];
  logic                  accept, mapped, commit_req, load, fall_strobe, clear;

  // Config port: a write transfers on a posedge where cfg_valid && cfg_ready;
  // the master holds addr/data stable while valid is high and not yet accepted.
  assign cfg_ready      = (state == IDLE);
  assign commit_pending = (state != IDLE);
  assign accept         = cfg_valid && cfg_ready;
  assign clear          = accept && (cfg_addr == ADDR_PRESCALE);
  assign commit_req     = accept && (cfg_addr == ADDR_COMMIT) && (|cfg_data[NUM_TIMERS-1:0]);

  always_comb begin
    mapped = (cfg_addr <= ADDR_COMMIT);
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (cfg_addr == ADDR_PERIOD_BASE + 4'(2*i) || cfg_addr == ADDR_PERIOD_BASE + 4'(2*i+1))
        mapped = 1'b1;
    end
  end

  tt_um_jimktrains_vslc_prescaler u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .prescale   (prescale),
    .clear      (clear),
    .timer_clk  (timer_clk),
    .fall_strobe(fall_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE:    if (commit_req) next_state = run ? PENDING : APPLY;
      PENDING: if (fall_strobe) begin
                 load       = 1'b1;
                 next_state = IDLE;
               end
      APPLY:   begin
                 load       = 1'b1;
                 next_state = IDLE;
               end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale       <= 16'd0;
      run            <= 1'b0;
      enable_sh      <= '0;
      commit_mask    <= '0;
      cfg_err        <= 1'b0;
      timer_period_a <= '0;
      timer_period_b <= '0;
      timer_enabled  <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        a_sh[i] <= 16'd0;
        b_sh[i] <= 16'd0;
      end
    end else begin
      cfg_err <= accept && !mapped;
      if (accept) begin
        case (cfg_addr)
          ADDR_PRESCALE:  prescale    <= cfg_data;
          ADDR_CTRL:      run         <= cfg_data[0];
          ADDR_ENABLE_SH: enable_sh   <= cfg_data[NUM_TIMERS-1:0];
          ADDR_COMMIT:    commit_mask <= cfg_data[NUM_TIMERS-1:0];
          default: ;
        endcase
        for (int i = 0; i < NUM_TIMERS; i++) begin
          if (cfg_addr == ADDR_PERIOD_BASE + 4'(2*i))   a_sh[i] <= cfg_data;
          if (cfg_addr == ADDR_PERIOD_BASE + 4'(2*i+1)) b_sh[i] <= cfg_data;
        end
      end
      // Only masked channels move; the mask was captured with the COMMIT write.
      if (load) begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
          if (commit_mask[i]) begin
            timer_period_a[16*i +: 16] <= a_sh[i];
            timer_period_b[16*i +: 16] <= b_sh[i];
            timer_enabled[i]           <= enable_sh[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_timer_sched.sv
// Directed bench for the VSLC timer scheduler with hand-computed expectations.
module tb_tt_um_jimktrains_vslc_timer_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_addr = 4'h0;
  logic [15:0] cfg_data = 16'h0;
  logic        cfg_err;
  logic        commit_pending;
  logic        timer_clk;
  logic [63:0] timer_period_a;
  logic [63:0] timer_period_b;
  logic [3:0]  timer_enabled;

  int tests = 0;
  int failures = 0;
  int waits;
  logic [11:0] pat;

  always #5 clk = ~clk;

  tt_um_jimktrains_vslc_timer_sched #(.NUM_TIMERS(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_err       (cfg_err),
    .commit_pending(commit_pending),
    .timer_clk     (timer_clk),
    .timer_period_a(timer_period_a),
    .timer_period_b(timer_period_b),
    .timer_enabled (timer_enabled)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d, output int n);
    n = 0;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    while (!cfg_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) check("wr_ready_timeout", {63'd0, cfg_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_timer_clk", {63'd0, timer_clk}, 64'd0);
    check("rst_ready", {63'd0, cfg_ready}, 64'd1);
    check("rst_err", {63'd0, cfg_err}, 64'd0);
    check("rst_pending", {63'd0, commit_pending}, 64'd0);
    check("rst_a", timer_period_a, 64'd0);
    check("rst_b", timer_period_b, 64'd0);
    check("rst_en", {60'd0, timer_enabled}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // prescale=2: 3-cycle half period
    cfg_write(4'h0, 16'd2, waits);
    cfg_write(4'h1, 16'd1, waits);
    check("run_start_clk", {63'd0, timer_clk}, 64'd0);
    pat = 12'b001110001110;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("presc2_clk_%0d", k), {63'd0, timer_clk}, {63'd0, pat[11-k]});
    end
    cfg_write(4'h1, 16'd0, waits);
    @(negedge clk);
    check("stop_clk_low", {63'd0, timer_clk}, 64'd0);

    // run=0 commit of channel 1
    cfg_write(4'hA, 16'd5, waits);
    cfg_write(4'hB, 16'd7, waits);
    cfg_write(4'h2, 16'h2, waits);
    check("shadow_only_a", timer_period_a, 64'd0);
    check("shadow_only_en", {60'd0, timer_enabled}, 64'd0);
    cfg_write(4'h3, 16'h2, waits);
    check("apply_pending", {63'd0, commit_pending}, 64'd1);
    check("apply_ready", {63'd0, cfg_ready}, 64'd0);
    check("apply_a_early", timer_period_a, 64'd0);
    @(negedge clk);
    check("apply_a", timer_period_a, 64'h0000_0000_0005_0000);
    check("apply_b", timer_period_b, 64'h0000_0000_0007_0000);
    check("apply_en", {60'd0, timer_enabled}, 64'h2);
    check("apply_done", {63'd0, commit_pending}, 64'd0);

    // run=1, prescale=3, commit channel 0 while timer_clk=0
    cfg_write(4'h8, 16'h11, waits);
    cfg_write(4'h9, 16'h22, waits);
    cfg_write(4'h2, 16'h3, waits);
    cfg_write(4'h0, 16'd3, waits);
    cfg_write(4'h1, 16'd1, waits);
    cfg_write(4'h3, 16'h1, waits);
    check("pend_clk0", {63'd0, timer_clk}, 64'd0);
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("pend_flag_%0d", k), {63'd0, commit_pending}, 64'd1);
      check($sformatf("pend_ready_%0d", k), {63'd0, cfg_ready}, 64'd0);
      check($sformatf("pend_a_%0d", k), timer_period_a, 64'h0000_0000_0005_0000);
      if (k == 8) check("pend_clk_high", {63'd0, timer_clk}, 64'd1);
    end
    @(negedge clk);
    check("fall_clk", {63'd0, timer_clk}, 64'd0);
    check("fall_pending", {63'd0, commit_pending}, 64'd0);
    check("fall_a", timer_period_a, 64'h0000_0000_0005_0011);
    check("fall_b", timer_period_b, 64'h0000_0000_0007_0022);
    check("fall_en", {60'd0, timer_enabled}, 64'h3);

    // valid held across PENDING
    cfg_write(4'h3, 16'h1, waits);
    cfg_write(4'h8, 16'd9, waits);
    check("held_wait_cycles", 64'(waits), 64'd7);
    check("held_active_a", timer_period_a, 64'h0000_0000_0005_0011);
    cfg_write(4'h1, 16'd0, waits);
    cfg_write(4'h3, 16'h1, waits);
    @(negedge clk);
    check("recommit_a", timer_period_a, 64'h0000_0000_0005_0009);

    // unmapped address and zero-mask commit
    cfg_write(4'h4, 16'hFFFF, waits);
    check("err_pulse", {63'd0, cfg_err}, 64'd1);
    @(negedge clk);
    check("err_one_cycle", {63'd0, cfg_err}, 64'd0);
    cfg_write(4'h7, 16'h1234, waits);
    check("err_addr7", {63'd0, cfg_err}, 64'd1);
    cfg_write(4'h3, 16'hFFF0, waits);
    check("mask0_err", {63'd0, cfg_err}, 64'd0);
    check("mask0_pending", {63'd0, commit_pending}, 64'd0);
    check("mask0_ready", {63'd0, cfg_ready}, 64'd1);
    @(negedge clk);
    check("mask0_still_idle", {63'd0, commit_pending}, 64'd0);
    check("err_a", timer_period_a, 64'h0000_0000_0005_0009);
    check("err_b", timer_period_b, 64'h0000_0000_0007_0022);
    check("err_en", {60'd0, timer_enabled}, 64'h3);

    // reset in the middle of PENDING
    cfg_write(4'h1, 16'd1, waits);
    cfg_write(4'hC, 16'h33, waits);
    cfg_write(4'h3, 16'h4, waits);
    @(negedge clk);
    check("mid_pending", {63'd0, commit_pending}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pending", {63'd0, commit_pending}, 64'd0);
    check("arst_ready", {63'd0, cfg_ready}, 64'd1);
    check("arst_a", timer_period_a, 64'd0);
    check("arst_b", timer_period_b, 64'd0);
    check("arst_en", {60'd0, timer_enabled}, 64'd0);
    check("arst_clk", {63'd0, timer_clk}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_a", timer_period_a, 64'd0);
    check("post_rst_en", {60'd0, timer_enabled}, 64'd0);
    check("post_rst_pending", {63'd0, commit_pending}, 64'd0);
    check("post_rst_clk", {63'd0, timer_clk}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
